// File: rtl/fpa_pkg.sv
// Shared types and constants for the floating-point round/pack back end.
package fpa_pkg;

    localparam int unsigned FPA_EXP_W     = 10;
    localparam int unsigned MANT_W        = 28;
    localparam int unsigned FRAC_W        = 23;

    // Bit positions inside the 28-bit working mantissa.
    localparam int unsigned MANT_CARRY    = 27;
    localparam int unsigned MANT_HIDDEN   = 26;
    localparam int unsigned MANT_FRAC_LSB = 3;
    localparam int unsigned MANT_G        = 2;
    localparam int unsigned MANT_R        = 1;
    localparam int unsigned MANT_S        = 0;

    localparam int          BIAS          = 127;
    localparam int          EXP_MAX       = 2 * BIAS + 1;
    localparam int          CLAMP_EXP     = -26;
    localparam logic [31:0] QNAN          = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        FPA_NORMAL = 2'd0,
        FPA_ZERO   = 2'd1,
        FPA_INF    = 2'd2,
        FPA_NAN    = 2'd3
    } fpa_class_t;

    typedef struct packed {
        logic                        sign;
        logic signed [FPA_EXP_W-1:0] exp;
        logic [MANT_W-1:0]           mant;
        fpa_class_t                  cls;
    } fpa_unpacked_t;

    // Fixed encodings for the non-NORMAL classes; NaN is always canonical.
    function automatic logic [31:0] fpa_pack_special(input fpa_class_t cls, input logic sign);
        logic [31:0] word;
        word = '0;
        case (cls)
            FPA_ZERO: word = {sign, 31'b0};
            FPA_INF:  word = {sign, 8'hFF, 23'b0};
            FPA_NAN:  word = QNAN;
            default:  word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/fpa_rne_round.sv
// Round-to-nearest-even on the normalized working mantissa.
module fpa_rne_round
    import fpa_pkg::*;
#(
    parameter int unsigned EXP_W = FPA_EXP_W
) (
    input  logic [MANT_HIDDEN:0]    mant_i,
    input  logic signed [EXP_W-1:0] exp_i,
    output logic [FRAC_W-1:0]       frac_c,
    output logic signed [EXP_W-1:0] exp_c,
    output logic                    hidden_c,
    output logic                    carry_c,
    output logic                    inexact_c
);

    localparam int unsigned SUM_W = MANT_HIDDEN - MANT_FRAC_LSB + 2;
    localparam logic signed [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    logic             inc;
    logic [SUM_W-1:0] sum;

    // Increment {hidden, fraction} on G and (R | S | LSB); a carry-out means 10.000.. -> 1.000.. at exp+1.
    always_comb begin
        inc       = mant_i[MANT_G] & (mant_i[MANT_R] | mant_i[MANT_S] | mant_i[MANT_FRAC_LSB]);
        sum       = {1'b0, mant_i[MANT_HIDDEN:MANT_FRAC_LSB]} + SUM_W'(inc);
        carry_c   = sum[SUM_W-1];
        hidden_c  = sum[SUM_W-2];
        frac_c    = sum[FRAC_W-1:0];
        exp_c     = sum[SUM_W-1] ? (exp_i + EXP_ONE) : exp_i;
        inexact_c = mant_i[MANT_G] | mant_i[MANT_R] | mant_i[MANT_S];
    end

endmodule

// File: rtl/fpa_round_pack.sv
// Normalizes, rounds (RNE) and packs an unpacked FP result into IEEE-754 single.
module fpa_round_pack
    import fpa_pkg::*;
#(
    parameter int unsigned EXP_W      = FPA_EXP_W,
    parameter int unsigned MAX_LSHIFT = 26
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_class,
    input  logic                    in_sign,
    input  logic signed [EXP_W-1:0] in_exp,
    input  logic [MANT_W-1:0]       in_mant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_number,
    output logic [2:0]              out_flags
);

    localparam int unsigned CNT_W = $clog2(MAX_LSHIFT + 1);
    localparam logic signed [FPA_EXP_W-1:0] EXP_ONE   = FPA_EXP_W'(1);
    localparam logic signed [FPA_EXP_W-1:0] EXP_OVF   = FPA_EXP_W'(EXP_MAX);
    localparam logic signed [EXP_W-1:0]     EXP_CLAMP = EXP_W'(CLAMP_EXP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic                        sign_q, sign_d;
    logic signed [FPA_EXP_W-1:0] exp_q, exp_d;
    logic [MANT_W-1:0]           mant_q, mant_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        in_ready_q, in_ready_d;
    logic                        out_valid_q, out_valid_d;
    logic [31:0]                 number_q, number_d;
    logic [2:0]                  flags_q, flags_d;

    fpa_unpacked_t               bundle_c;

    logic [FRAC_W-1:0]           rnd_frac;
    logic signed [FPA_EXP_W-1:0] rnd_exp;
    logic                        rnd_hidden;
    logic                        rnd_carry;
    logic                        rnd_inexact;
    logic                        rnd_norm;

    // Incoming operand bundle, with far-subnormal inputs collapsed to a lone sticky bit.
    always_comb begin
        bundle_c.sign = in_sign;
        bundle_c.cls  = fpa_class_t'(in_class);
        bundle_c.exp  = FPA_EXP_W'(in_exp);
        bundle_c.mant = in_mant;
        if (in_exp < EXP_CLAMP) begin
            bundle_c.exp  = EXP_ONE;
            bundle_c.mant = {{(MANT_W-1){1'b0}}, |in_mant};
        end
    end

    fpa_rne_round #(
        .EXP_W (FPA_EXP_W)
    ) u_rne_round (
        .mant_i    (mant_q[MANT_HIDDEN:0]),
        .exp_i     (exp_q),
        .frac_c    (rnd_frac),
        .exp_c     (rnd_exp),
        .hidden_c  (rnd_hidden),
        .carry_c   (rnd_carry),
        .inexact_c (rnd_inexact)
    );

    // After a rounding carry the value is 1.0 at exp+1, so it is normal.
    assign rnd_norm = rnd_carry | rnd_hidden;

    // Next-state, datapath and output-register updates.
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        number_d    = number_q;
        flags_d     = flags_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    in_ready_d = 1'b0;
                    cnt_d      = '0;
                    sign_d     = bundle_c.sign;
                    exp_d      = bundle_c.exp;
                    mant_d     = bundle_c.mant;
                    if (bundle_c.cls == FPA_NORMAL) begin
                        state_d = ST_NORM;
                    end else begin
                        number_d    = fpa_pack_special(bundle_c.cls, bundle_c.sign);
                        flags_d     = 3'b000;
                        out_valid_d = 1'b1;
                        state_d     = ST_OUT;
                    end
                end
            end

            ST_NORM: begin
                if (mant_q[MANT_CARRY] || (exp_q < EXP_ONE)) begin
                    mant_d = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
                    exp_d  = exp_q + EXP_ONE;
                end else if (!mant_q[MANT_HIDDEN] && (|mant_q[MANT_HIDDEN:0]) &&
                             (exp_q > EXP_ONE) && (cnt_q < CNT_W'(MAX_LSHIFT))) begin
                    mant_d = {mant_q[MANT_W-2:0], 1'b0};
                    exp_d  = exp_q - EXP_ONE;
                    cnt_d  = cnt_q + CNT_W'(1);
                end else begin
                    state_d = ST_ROUND;
                end
            end

            ST_ROUND: begin
                if (rnd_exp >= EXP_OVF) begin
                    number_d = {sign_q, 8'hFF, {FRAC_W{1'b0}}};
                    flags_d  = 3'b101;
                end else begin
                    number_d = {sign_q, (rnd_norm ? rnd_exp[7:0] : 8'h00), rnd_frac};
                    flags_d  = {1'b0, !mant_q[MANT_HIDDEN] & rnd_inexact, rnd_inexact};
                end
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end

            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any bundle in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            number_q    <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            number_q    <= number_d;
            flags_q     <= flags_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_number = number_q;
    assign out_flags  = flags_q;

endmodule

// File: tb/tb_fpa_round_pack.sv
// Scoreboard bench for fpa_round_pack: results, flags, latency, backpressure and reset abort.
module tb_fpa_round_pack;
    import fpa_pkg::*;

    localparam int unsigned EXP_W = 10;

    logic                    clk       = 1'b0;
    logic                    rst       = 1'b0;
    logic                    in_valid  = 1'b0;
    logic                    in_ready;
    logic [1:0]              in_class  = 2'd0;
    logic                    in_sign   = 1'b0;
    logic signed [EXP_W-1:0] in_exp    = '0;
    logic [27:0]             in_mant   = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic [31:0]             out_number;
    logic [2:0]              out_flags;

    typedef struct {
        logic [31:0] num;
        logic [2:0]  flags;
        int          lat;
        int          cap;
    } exp_t;

    typedef struct {
        fpa_class_t  cls;
        logic        sign;
        int          e;
        logic [27:0] mant;
        logic [31:0] num;
        logic [2:0]  flags;
        int          lat;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   tx_idx   = 0;
    bit   reported = 1'b0;

    fpa_round_pack #(
        .EXP_W      (EXP_W),
        .MAX_LSHIFT (26)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_class   (in_class),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_number (out_number),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic vec_t mk(input fpa_class_t c, input logic s, input int e,
                                input logic [27:0] m, input logic [31:0] n,
                                input logic [2:0] f, input int l);
        vec_t v;
        v.cls = c; v.sign = s; v.e = e; v.mant = m; v.num = n; v.flags = f; v.lat = l;
        return v;
    endfunction

    // Drive one bundle until captured; optionally register its expected result.
    task automatic send(input vec_t v, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_class = v.cls;
        in_sign  = v.sign;
        in_exp   = EXP_W'(v.e);
        in_mant  = v.mant;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("capture_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        if (push) sb_q.push_back('{v.num, v.flags, v.lat, cyc + 1});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Wait until every expected result has been seen and the output handshake has closed.
    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb_q.size()), 64'd0);
    endtask

    // Compare each new result against the oldest pending expectation.
    always @(negedge clk) begin
        if (rst && out_valid && !reported) begin
            reported = 1'b1;
            if (sb_q.size() == 0) begin
                chk("spurious_valid", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk($sformatf("number[%0d]", tx_idx), 64'(out_number), 64'(e.num));
                chk($sformatf("flags[%0d]", tx_idx), 64'(out_flags), 64'(e.flags));
                chk($sformatf("latency[%0d]", tx_idx), 64'(cyc - e.cap + 1), 64'(e.lat));
                tx_idx++;
            end
        end else if (!out_valid) begin
            reported = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vec_t one;

        vecs.push_back(mk(FPA_NORMAL, 1'b0, 127, 28'h4000000, 32'h3F80_0000, 3'b000, 3));
        vecs.push_back(mk(FPA_NORMAL, 1'b0, 127, 28'h8000000, 32'h4000_0000, 3'b000, 4));
        vecs.push_back(mk(FPA_NORMAL, 1'b0, 127, 28'h7FFFFFC, 32'h4000_0000, 3'b001, 3));
        vecs.push_back(mk(FPA_NORMAL, 1'b0, 127, 28'h4000004, 32'h3F80_0000, 3'b001, 3));
        vecs.push_back(mk(FPA_NORMAL, 1'b0, 254, 28'h7FFFFFC, 32'h7F80_0000, 3'b101, 3));
        vecs.push_back(mk(FPA_NORMAL, 1'b0, 0,   28'h4000000, 32'h0040_0000, 3'b000, 4));
        vecs.push_back(mk(FPA_NORMAL, 1'b0, 0,   28'h4000001, 32'h0040_0000, 3'b011, 4));
        vecs.push_back(mk(FPA_NAN,    1'b1, 0,   28'h0000000, 32'h7FC0_0000, 3'b000, 1));
        vecs.push_back(mk(FPA_INF,    1'b1, 0,   28'h0000000, 32'hFF80_0000, 3'b000, 1));
        vecs.push_back(mk(FPA_NORMAL, 1'b1, 127, 28'h0000000, 32'h8000_0000, 3'b000, 3));
        vecs.push_back(mk(FPA_ZERO,   1'b1, 5,   28'h0000123, 32'h8000_0000, 3'b000, 1));
        vecs.push_back(mk(FPA_NORMAL, 1'b0, 127, 28'h2000000, 32'h3F00_0000, 3'b000, 4));
        vecs.push_back(mk(FPA_NORMAL, 1'b1, 128, 28'h6000000, 32'hC040_0000, 3'b000, 3));
        vecs.push_back(mk(FPA_NORMAL, 1'b0, -40, 28'h4000000, 32'h0000_0000, 3'b011, 3));
        vecs.push_back(mk(FPA_NORMAL, 1'b0, 0,   28'h7FFFFFF, 32'h0080_0000, 3'b011, 4));
        one = mk(FPA_NORMAL, 1'b0, 127, 28'h4000000, 32'h3F80_0000, 3'b000, 3);

        // Reset values while held, then ready as soon as reset is released.
        repeat (3) @(negedge clk);
        chk("rst_valid",  64'(out_valid),  64'd0);
        chk("rst_number", 64'(out_number), 64'd0);
        chk("rst_flags",  64'(out_flags),  64'd0);
        rst = 1'b1;
        #1 chk("rst_ready", 64'(in_ready), 64'd1);

        foreach (vecs[i]) begin
            send(vecs[i], 1'b1);
            drain();
        end

        // Backpressure: result frozen, input blocked, and in_valid ignored meanwhile.
        out_ready = 1'b0;
        send(one, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", 64'(out_valid), 64'd1);
        in_valid = 1'b1;
        in_class = FPA_NAN;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_number", 64'(out_number), 64'h3F80_0000);
            chk("hold_flags",  64'(out_flags),  64'd0);
            chk("hold_valid",  64'(out_valid),  64'd1);
            chk("hold_ready",  64'(in_ready),   64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (3) @(negedge clk);
        chk("ignored_valid", 64'(out_valid), 64'd0);

        // Reset during a long left-normalization aborts the bundle.
        send(mk(FPA_NORMAL, 1'b0, 127, 28'h0000008, 32'h0, 3'b000, 26), 1'b0);
        repeat (5) @(negedge clk);
        chk("norm_busy", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("abort_valid",  64'(out_valid),  64'd0);
        chk("abort_number", 64'(out_number), 64'd0);
        chk("abort_flags",  64'(out_flags),  64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_ready",   64'(in_ready),  64'd1);
        chk("abort_valid_2", 64'(out_valid), 64'd0);
        repeat (40) @(negedge clk);
        chk("aborted_quiet", 64'(out_valid), 64'd0);

        send(one, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
